// File: rtl/engine_bin_port_pkg.sv
// engine_bin_port_pkg
// Shared constants and types for the bin port and its load/update dispatcher.
//   NUM_CLAUSES_A_BIN / NUM_VARS_A_BIN  : rows and variables held by one bin
//   WIDTH_BIN_CLAUSES / WIDTH_VAR_STATES: clause row and variable state widths
//   ROW_ADDR_W                          : width of engine row / variable index
//   bin_state_e                         : bin lifecycle state
package engine_bin_port_pkg;

    localparam int NUM_CLAUSES_A_BIN = 24;
    localparam int NUM_VARS_A_BIN    = 24;
    localparam int WIDTH_BIN_CLAUSES = 48;
    localparam int WIDTH_VAR_STATES  = 30;
    localparam int ROW_ADDR_W        = 5;

    typedef logic [WIDTH_BIN_CLAUSES-1:0] clause_row_t;
    typedef logic [WIDTH_VAR_STATES-1:0]  var_state_t;
    typedef logic [ROW_ADDR_W-1:0]        row_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOADING  = 2'd1,
        ST_READY    = 2'd2,
        ST_UPDATING = 2'd3
    } bin_state_e;

endpackage

// File: rtl/engine_bin_port_row_store.sv
// bin_row_store
// Register array with one write port and one registered read port.
//   clk, rst          : rising-edge clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data : write at the next edge; addresses >= DEPTH ignored
//   rd_addr / rd_data : rd_data is the entry addressed in the previous cycle,
//                       0 for addresses >= DEPTH; a same-cycle write to the
//                       read entry is not visible (old data returned)
// Reset clears every entry and the read register.
module bin_row_store
    import engine_bin_port_pkg::*;
#(
    parameter int DEPTH = NUM_CLAUSES_A_BIN,
    parameter int WIDTH = WIDTH_BIN_CLAUSES,
    parameter int AW    = ROW_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_comb begin
        mem_d     = mem_q;
        rd_data_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == AW'(i))) begin
                mem_d[i] = wr_data;
            end
            // Read from the pre-write contents so read-during-write returns old data.
            if (rd_addr == AW'(i)) begin
                rd_data_d = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/engine_bin_port.sv
// engine_bin_port
// Holds one bin of clause rows and variable states between the dispatcher
// and a solver engine.
//   Load side   : wr_lit_cells (one-hot row), clauses_i/clauses_valid_i,
//                 vars_states_i/vars_states_valid_i (index order), load_done_i
//   Update side : start_update_i, rd_lit_cells (one-hot row),
//                 clauses_o/clauses_valid_o, vars_states_o/vars_states_valid_o
//   Engine side : eng_addr/eng_wr/eng_wdata/eng_rdata (rows),
//                 eng_vidx/eng_vwr/eng_vwdata/eng_vrdata (variable states)
//   Status      : bin_ready_o, update_busy_o, err_o (sticky), state_o (debug)
// Valid semantics: every *_valid_i / pulse input is sampled on each rising
// edge where it is high; there is no back-pressure. Outputs are qualified by
// their *_valid_o and are forced to 0 when not valid.
module engine_bin_port #(
    parameter int NUM_CLAUSES_A_BIN = engine_bin_port_pkg::NUM_CLAUSES_A_BIN,
    parameter int NUM_VARS_A_BIN    = engine_bin_port_pkg::NUM_VARS_A_BIN,
    parameter int WIDTH_BIN_CLAUSES = engine_bin_port_pkg::WIDTH_BIN_CLAUSES,
    parameter int WIDTH_VAR_STATES  = engine_bin_port_pkg::WIDTH_VAR_STATES
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_CLAUSES_A_BIN-1:0]             wr_lit_cells,
    input  logic [WIDTH_BIN_CLAUSES-1:0]             clauses_i,
    input  logic                                     clauses_valid_i,
    input  logic [WIDTH_VAR_STATES-1:0]              vars_states_i,
    input  logic                                     vars_states_valid_i,
    input  logic                                     load_done_i,
    input  logic                                     start_update_i,
    input  logic [NUM_CLAUSES_A_BIN-1:0]             rd_lit_cells,
    output logic [WIDTH_BIN_CLAUSES-1:0]             clauses_o,
    output logic                                     clauses_valid_o,
    output logic [WIDTH_VAR_STATES-1:0]              vars_states_o,
    output logic                                     vars_states_valid_o,
    input  logic [engine_bin_port_pkg::ROW_ADDR_W-1:0] eng_addr,
    input  logic                                     eng_wr,
    input  logic [WIDTH_BIN_CLAUSES-1:0]             eng_wdata,
    output logic [WIDTH_BIN_CLAUSES-1:0]             eng_rdata,
    input  logic [engine_bin_port_pkg::ROW_ADDR_W-1:0] eng_vidx,
    input  logic                                     eng_vwr,
    input  logic [WIDTH_VAR_STATES-1:0]              eng_vwdata,
    output logic [WIDTH_VAR_STATES-1:0]              eng_vrdata,
    output logic                                     bin_ready_o,
    output logic                                     update_busy_o,
    output logic                                     err_o,
    output engine_bin_port_pkg::bin_state_e          state_o
);

    import engine_bin_port_pkg::*;

    localparam int AW = ROW_ADDR_W;

    function automatic logic is_onehot(input logic [NUM_CLAUSES_A_BIN-1:0] sel);
        return (sel != '0) && ((sel & (sel - NUM_CLAUSES_A_BIN'(1))) == '0);
    endfunction

    function automatic logic [AW-1:0] onehot_idx(input logic [NUM_CLAUSES_A_BIN-1:0] sel);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CLAUSES_A_BIN; i++) begin
            if (sel[i]) idx = AW'(i);
        end
        return idx;
    endfunction

    bin_state_e    state_q, state_d;
    logic [AW-1:0] v_cnt_q, v_cnt_d;   // next variable entry to load (0..NUM_VARS_A_BIN)
    logic [AW-1:0] s_cnt_q, s_cnt_d;   // variable entry currently on vars_states_o
    logic          err_q, err_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          cl_vld_q, cl_vld_d;
    logic          vs_vld_q, vs_vld_d;
    logic          eng_rd_q, eng_rd_d;
    logic          eng_vrd_q, eng_vrd_d;

    logic                         c_wr_en;
    logic [AW-1:0]                c_wr_addr, c_rd_addr;
    logic [WIDTH_BIN_CLAUSES-1:0] c_wr_data, c_rd_data;
    logic                         v_wr_en;
    logic [AW-1:0]                v_wr_addr, v_rd_addr;
    logic [WIDTH_VAR_STATES-1:0]  v_wr_data, v_rd_data;

    logic          load_word;
    logic [AW-1:0] v_base;

    always_comb begin
        state_d   = state_q;
        v_cnt_d   = v_cnt_q;
        s_cnt_d   = s_cnt_q;
        err_d     = err_q;
        cl_vld_d  = 1'b0;
        vs_vld_d  = 1'b0;
        eng_rd_d  = 1'b0;
        eng_vrd_d = 1'b0;
        c_wr_en   = 1'b0;
        c_wr_addr = '0;
        c_wr_data = '0;
        c_rd_addr = '0;
        v_wr_en   = 1'b0;
        v_wr_addr = '0;
        v_wr_data = '0;
        v_rd_addr = '0;

        load_word = clauses_valid_i | vars_states_valid_i;
        // Entering LOADING (from IDLE or READY) restarts the variable index.
        v_base    = (state_q == ST_LOADING) ? v_cnt_q : '0;

        // Load side: accepted in IDLE, LOADING and READY (a new word in
        // READY starts overwriting the bin).
        if (load_word) begin
            if (state_q == ST_UPDATING) begin
                err_d = 1'b1;
            end else begin
                state_d = ST_LOADING;
                v_cnt_d = v_base;
                if (clauses_valid_i) begin
                    if (is_onehot(wr_lit_cells)) begin
                        c_wr_en   = 1'b1;
                        c_wr_addr = onehot_idx(wr_lit_cells);
                        c_wr_data = clauses_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (vars_states_valid_i) begin
                    if (v_base < AW'(NUM_VARS_A_BIN)) begin
                        v_wr_en   = 1'b1;
                        v_wr_addr = v_base;
                        v_wr_data = vars_states_i;
                        v_cnt_d   = v_base + AW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        end

        if (load_done_i) begin
            if (state_q == ST_LOADING) state_d = ST_READY;
            else                       err_d   = 1'b1;
        end

        // Engine port owns both stores while the bin sits in READY.
        if (state_q == ST_READY) begin
            c_rd_addr = eng_addr;
            v_rd_addr = eng_vidx;
            eng_rd_d  = 1'b1;
            eng_vrd_d = 1'b1;
            if (!load_word) begin
                c_wr_en   = eng_wr;
                c_wr_addr = eng_addr;
                c_wr_data = eng_wdata;
                v_wr_en   = eng_vwr;
                v_wr_addr = eng_vidx;
                v_wr_data = eng_vwdata;
            end
        end

        // A start coinciding with a reload cannot be honoured.
        if (start_update_i) begin
            if ((state_q == ST_READY) && !load_word) begin
                state_d   = ST_UPDATING;
                s_cnt_d   = '0;
                vs_vld_d  = 1'b1;
                v_rd_addr = '0;      // prefetch entry 0 so it appears next cycle
                eng_vrd_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end

        if (state_q == ST_UPDATING) begin
            if (s_cnt_q == AW'(NUM_VARS_A_BIN - 1)) begin
                state_d = ST_IDLE;
                s_cnt_d = '0;
            end else begin
                s_cnt_d   = s_cnt_q + AW'(1);
                vs_vld_d  = 1'b1;
                v_rd_addr = s_cnt_q + AW'(1);
            end
            if (rd_lit_cells != '0) begin
                if (is_onehot(rd_lit_cells)) begin
                    c_rd_addr = onehot_idx(rd_lit_cells);
                    cl_vld_d  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        ready_d = (state_d == ST_READY);
        busy_d  = (state_d == ST_UPDATING);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            v_cnt_q   <= '0;
            s_cnt_q   <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            cl_vld_q  <= 1'b0;
            vs_vld_q  <= 1'b0;
            eng_rd_q  <= 1'b0;
            eng_vrd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_cnt_q   <= v_cnt_d;
            s_cnt_q   <= s_cnt_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            cl_vld_q  <= cl_vld_d;
            vs_vld_q  <= vs_vld_d;
            eng_rd_q  <= eng_rd_d;
            eng_vrd_q <= eng_vrd_d;
        end
    end

    bin_row_store #(
        .DEPTH (NUM_CLAUSES_A_BIN),
        .WIDTH (WIDTH_BIN_CLAUSES),
        .AW    (AW)
    ) u_clause_store (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (c_wr_en),
        .wr_addr (c_wr_addr),
        .wr_data (c_wr_data),
        .rd_addr (c_rd_addr),
        .rd_data (c_rd_data)
    );

    bin_row_store #(
        .DEPTH (NUM_VARS_A_BIN),
        .WIDTH (WIDTH_VAR_STATES),
        .AW    (AW)
    ) u_var_store (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (v_wr_en),
        .wr_addr (v_wr_addr),
        .wr_data (v_wr_data),
        .rd_addr (v_rd_addr),
        .rd_data (v_rd_data)
    );

    // Each store has a single read register; the qualifier flops say who
    // issued last cycle's read so only that consumer sees the data.
    assign clauses_o           = cl_vld_q  ? c_rd_data : '0;
    assign clauses_valid_o     = cl_vld_q;
    assign eng_rdata           = eng_rd_q  ? c_rd_data : '0;
    assign vars_states_o       = vs_vld_q  ? v_rd_data : '0;
    assign vars_states_valid_o = vs_vld_q;
    assign eng_vrdata          = eng_vrd_q ? v_rd_data : '0;
    assign bin_ready_o         = ready_q;
    assign update_busy_o       = busy_q;
    assign err_o               = err_q;
    assign state_o             = state_q;

endmodule

// File: doc/engine_bin_port.md
ENGINE_BIN_PORT -- requirements
Module: engine_bin_port

Interface
REQ-001 Parameter NUM_CLAUSES_A_BIN, 24, clause rows per bin.
REQ-002 Parameter NUM_VARS_A_BIN, 24, variables per bin.
REQ-003 Parameter WIDTH_BIN_CLAUSES, 48, bits per clause row (2 bits per literal).
REQ-004 Parameter WIDTH_VAR_STATES, 30, bits per variable state word.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 wr_lit_cells  in  NUM_CLAUSES_A_BIN  one-hot row select for a load write.
REQ-008 clauses_i / clauses_valid_i  in  WIDTH_BIN_CLAUSES / 1  clause row and its qualifier, from the dispatcher.
REQ-009 vars_states_i / vars_states_valid_i  in  WIDTH_VAR_STATES / 1  variable state stream, in variable-index order.
REQ-010 load_done_i  in  1  one-cycle pulse marking end of load.
REQ-011 start_update_i  in  1  one-cycle pulse requesting write-back.
REQ-012 rd_lit_cells  in  NUM_CLAUSES_A_BIN  one-hot row select for an update read.
REQ-013 clauses_o / clauses_valid_o  out  WIDTH_BIN_CLAUSES / 1  returned clause row and its qualifier.
REQ-014 vars_states_o / vars_states_valid_o  out  WIDTH_VAR_STATES / 1  returned state stream.
REQ-015 eng_addr / eng_wr / eng_wdata / eng_rdata  in / in / in WIDTH_BIN_CLAUSES / out WIDTH_BIN_CLAUSES  engine row port; the address is 5 bits.
REQ-016 eng_vidx / eng_vwr / eng_vwdata / eng_vrdata  in 5 / in 1 / in WIDTH_VAR_STATES / out WIDTH_VAR_STATES  engine variable-state port.
REQ-017 bin_ready_o, update_busy_o, err_o  out  1 each  bin loaded; write-back in progress; sticky protocol error.

Function
REQ-018 The block SHALL implement states IDLE, LOADING, READY and UPDATING.
REQ-019 State transitions:
- IDLE->LOADING on the first clauses_valid_i or vars_states_valid_i.
- LOADING->READY on load_done_i.
- READY->UPDATING on start_update_i.
- UPDATING->IDLE one cycle after the last variable state is emitted.
- READY->LOADING on a new valid load word, which overwrites the bin.
REQ-020 In IDLE/LOADING, clauses_valid_i with one-hot wr_lit_cells SHALL write clauses_i into the selected row at the next edge.
- A zero or multi-hot select SHALL write nothing and set err_o.
REQ-021 Each vars_states_valid_i SHALL write entry v_cnt, then increment v_cnt; v_cnt clears on entry to LOADING.
- A word arriving with v_cnt==NUM_VARS_A_BIN SHALL be dropped and set err_o; there is no wrap-around.
REQ-022 bin_ready_o SHALL be high exactly while in READY.
REQ-023 The engine port SHALL act only in READY:
- eng_rdata / eng_vrdata are registered with 1-cycle latency.
- eng_wr / eng_vwr write at the next edge.
- Same-cycle read and write of the same entry returns the old data.
- Addresses >= 24 are ignored on write and read as 0.
REQ-024 In UPDATING, a one-hot rd_lit_cells in cycle N SHALL drive that row on clauses_o with clauses_valid_o=1 in cycle N+1.
- Otherwise clauses_valid_o=0 and clauses_o=0.
- A multi-hot select sets err_o.
REQ-025 In UPDATING, the block SHALL stream entries 0..NUM_VARS_A_BIN-1 on vars_states_o, one per cycle, starting the cycle after start_update_i, with vars_states_valid_o=1.
- clauses_o and vars_states_o operate concurrently.
REQ-026 update_busy_o SHALL be high throughout UPDATING.
REQ-027 start_update_i outside READY, and load_done_i outside LOADING, SHALL be ignored and set err_o.
REQ-028 Load-side valid inputs during UPDATING SHALL be ignored and set err_o.
REQ-029 err_o SHALL clear only on reset.

Reset
REQ-030 While rst=0 the block SHALL hold IDLE; every output, v_cnt and the stream counter are 0.
REQ-031 Reset SHALL clear all row and state storage.
REQ-032 Reset asserted mid-LOADING or mid-UPDATING SHALL abort the operation; outputs are 0 at the first edge with rst=0.

Structure
REQ-033 A shared package SHALL hold the four parameters as constants, the state enumeration, and the row/state word widths, shared with the load/update dispatcher.
REQ-034 Row storage SHALL be one sub-module, bin_row_store: a register array with one write port and one registered read port, instantiated for clause rows and for variable states.

Verification
REQ-035 Full load, then load_done_i -> bin_ready_o=1 the next cycle.
- Load: 24 rows with wr_lit_cells=1<<k, data=k, plus 24 states 100+k.
- eng_addr=5 returns 5; eng_vidx=7 returns 107, each one cycle later.
REQ-036 In READY, eng_wr row 3 := 0xABC, then start_update_i, then rd_lit_cells=1<<3.
- Required: clauses_o=0xABC with valid in the following cycle.
- Required: vars_states_o streams 100..123 over 24 consecutive cycles, then IDLE.
REQ-037 A 25th vars_states_valid_i, and separately wr_lit_cells=0b11 with valid -> err_o=1, no storage change.
REQ-038 start_update_i in IDLE -> err_o=1, update_busy_o stays 0.
REQ-039 rst=0 at stream entry 10 of UPDATING -> at the first edge with rst=0, all outputs 0 and state IDLE; reading row 0 after reload returns the new data.
